// File: rtl/motor_ramp.sv
`default_nettype none
// ============================================================================
// Module   : motor_ramp
// Purpose  : Command conditioning ahead of the motor PWM generator. Accepts a
//            target speed/direction, slews the applied speed toward it at a
//            programmable rate, and forces a stop plus dwell before any
//            direction reversal. Emergency stop overrides all commands.
// Revision : 1.0  initial release
// ============================================================================
module motor_ramp #(
    parameter int DWELL_TICKS = 4,     // ramp ticks held at speed 0 before a flip (>=1)
    parameter bit DIR_RESET   = 1'b1   // dir after reset, 1 = forward
) (
    input  logic        clk,
    input  logic        rst,           // synchronous, active-low
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [7:0]  cmd_spd,
    input  logic [15:0] ramp_div,
    input  logic [7:0]  ramp_step,
    input  logic        estop,
    output logic [7:0]  spd_sel,
    output logic        dir,
    output logic        en,
    output logic        at_target,
    output logic        busy
);

    // Dwell counter only ever holds 0..DWELL_TICKS-1; it clears on the flip.
    localparam int c_DWELL_W = (DWELL_TICKS < 2) ? 1 : $clog2(DWELL_TICKS);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_TICKS - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_DWELL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [7:0]             r_spd;
    logic                   r_dir;
    logic                   r_en;
    logic                   r_ready;
    logic                   r_at_target;
    logic                   r_busy;
    logic [7:0]             r_tgt_spd;
    logic                   r_tgt_dir;
    logic [15:0]            r_presc;
    logic [c_DWELL_W-1:0]   r_dwell;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [15:0]            w_div;
    logic [7:0]             w_step;
    logic                   w_active;
    logic                   w_tick;
    logic                   w_mismatch;
    logic                   w_on_target;
    logic                   w_accept;
    logic [8:0]             w_diff;
    logic                   w_up;
    logic [7:0]             w_mag;
    logic [7:0]             w_mv;
    logic [7:0]             w_spd_toward;
    logic [7:0]             w_dn;
    logic [7:0]             w_spd_down;

    // Zero divider / zero step are treated as 1.
    assign w_div  = (ramp_div  == 16'd0) ? 16'd1 : ramp_div;
    assign w_step = (ramp_step == 8'd0)  ? 8'd1  : ramp_step;

    // The prescaler only runs while the speed is in motion or dwelling.
    assign w_active = (r_state == ST_RAMP) || (r_state == ST_DWELL);

    // A >= compare keeps the tick coming if ramp_div is lowered below the
    // current prescaler value instead of waiting for a 16-bit wrap.
    assign w_tick = w_active && (r_presc >= (w_div - 16'd1));

    // A zero target never asks for a direction change.
    assign w_mismatch  = (r_dir != r_tgt_dir) && (r_tgt_spd != 8'd0);
    assign w_on_target = (r_spd == r_tgt_spd) &&
                         ((r_tgt_spd == 8'd0) || (r_dir == r_tgt_dir));

    assign w_accept = cmd_valid && r_ready;

    // Nine-bit difference: bit 8 set means the target lies below the speed.
    // The low byte negated gives the magnitude in the downward case.
    assign w_diff       = {1'b0, r_tgt_spd} - {1'b0, r_spd};
    assign w_up         = ~w_diff[8];
    assign w_mag        = w_up ? w_diff[7:0] : (8'd0 - w_diff[7:0]);
    assign w_mv         = (w_step < w_mag) ? w_step : w_mag;
    assign w_spd_toward = w_up ? (r_spd + w_mv) : (r_spd - w_mv);

    // Ramp-down toward zero used while a reversal is pending.
    assign w_dn       = (w_step < r_spd) ? w_step : r_spd;
    assign w_spd_down = r_spd - w_dn;

    // ------------------------------------------------------------------
    // Next-state values for the normal (no reset, no estop) path
    // ------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [7:0]             w_spd_nxt;
    logic                   w_dir_nxt;
    logic [15:0]            w_presc_nxt;
    logic [c_DWELL_W-1:0]   w_dwell_nxt;

    // Ramp/dwell decisions taken on each prescaler tick against the target
    // as it stood before any command accepted on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_spd_nxt   = r_spd;
        w_dir_nxt   = r_dir;
        w_dwell_nxt = r_dwell;
        w_presc_nxt = 16'd0;

        if (w_active) begin
            w_presc_nxt = w_tick ? 16'd0 : (r_presc + 16'd1);
        end

        case (r_state)
            ST_IDLE: begin
                if (r_tgt_spd != 8'd0) begin
                    w_state_nxt = ST_RAMP;
                end
            end

            ST_RAMP: begin
                if (w_tick) begin
                    if (w_mismatch) begin
                        if (r_spd != 8'd0) begin
                            w_spd_nxt = w_spd_down;
                        end else begin
                            w_state_nxt = ST_DWELL;
                            w_dwell_nxt = '0;
                        end
                    end else begin
                        w_spd_nxt = w_spd_toward;
                        if (w_spd_toward == r_tgt_spd) begin
                            w_state_nxt = (r_tgt_spd != 8'd0) ? ST_HOLD : ST_IDLE;
                        end
                    end
                end
            end

            ST_DWELL: begin
                if (w_tick) begin
                    if (!w_mismatch) begin
                        // Target changed so no reversal is needed any more.
                        w_state_nxt = (r_tgt_spd != 8'd0) ? ST_RAMP : ST_IDLE;
                        w_dwell_nxt = '0;
                    end else if (r_dwell == c_DWELL_LAST) begin
                        w_dir_nxt   = r_tgt_dir;
                        w_state_nxt = ST_RAMP;
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + c_DWELL_ONE;
                    end
                end
            end

            ST_HOLD: begin
                if (!w_on_target) begin
                    w_state_nxt = ST_RAMP;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, outputs and target register; reset beats estop, estop beats commands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_spd       <= 8'd0;
            r_dir       <= DIR_RESET;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_at_target <= 1'b1;
            r_busy      <= 1'b0;
            r_tgt_spd   <= 8'd0;
            r_tgt_dir   <= DIR_RESET;
            r_presc     <= 16'd0;
            r_dwell     <= '0;
        end else if (estop) begin
            // Direction is left alone so a restart in the same direction
            // does not need a dwell.
            r_state     <= ST_IDLE;
            r_spd       <= 8'd0;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_at_target <= 1'b1;
            r_busy      <= 1'b0;
            r_tgt_spd   <= 8'd0;
            r_presc     <= 16'd0;
            r_dwell     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_spd       <= w_spd_nxt;
            r_dir       <= w_dir_nxt;
            r_en        <= 1'b1;
            r_ready     <= 1'b1;
            r_presc     <= w_presc_nxt;
            r_dwell     <= w_dwell_nxt;
            r_at_target <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD);
            r_busy      <= (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_DWELL);
            if (w_accept) begin
                r_tgt_spd <= cmd_spd;
                r_tgt_dir <= cmd_dir;
            end
        end
    end

    assign spd_sel   = r_spd;
    assign dir       = r_dir;
    assign en        = r_en;
    assign cmd_ready = r_ready;
    assign at_target = r_at_target;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/motor_ramp.md
Name: motor_ramp

Overview:
- Command-conditioning stage directly upstream of the motor PWM generator.
- Accepts commanded speed and direction over a valid/ready handshake.
- Slews the applied speed toward the target at a programmable rate and forces a pass through zero, plus a dwell, before any direction reversal.
- Drives the PWM generator's spd_sel, dir and en inputs; an emergency stop overrides everything.

Parameters:
DWELL_TICKS, 4, ramp ticks held at speed 0 before the direction flips (>=1)
DIR_RESET, 1, dir value after reset (1 = forward)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_dir  in  1  target direction, 1 forward / 0 reverse
cmd_spd  in  8  target speed 0-255
ramp_div  in  16  clk cycles per ramp tick; 0 treated as 1
ramp_step  in  8  speed change per tick; 0 treated as 1
estop  in  1  emergency stop, level-sensitive
spd_sel  out  8  applied speed to PWM generator
dir  out  1  applied direction to PWM generator
en  out  1  PWM enable, equals registered ~estop
at_target  out  1  applied speed/dir equal target
busy  out  1  state is RAMP or DWELL

Behaviour:
- All outputs registered. On rst=0 at a clk edge:
  - spd_sel=0, dir=DIR_RESET, en=0, at_target=1, busy=0, cmd_ready=0.
  - Target cleared to speed 0, direction DIR_RESET; state=IDLE; prescaler=0; dwell counter=0.
- cmd_ready=1 in every state whenever estop=0 and not in reset.
- Command acceptance:
  - On valid&ready, target is overwritten with {cmd_dir, cmd_spd}; the latest accepted command always wins, including mid-ramp or mid-dwell.
  - The state update takes effect on the cycle after acceptance.
- Prescaler:
  - Counts 0..div-1, where div = max(ramp_div, 1); tick = (prescaler == div-1).
  - Runs only in RAMP and DWELL; held at 0 in IDLE and HOLD.
  - First tick therefore arrives div cycles after entering RAMP.
- Direction mismatch: "mismatch" means dir != target dir AND target speed != 0. A target of 0 never flips dir.
- States:
  - IDLE: spd_sel=0, target speed 0. Accepted target speed != 0 -> RAMP.
  - RAMP, on each tick:
    - Mismatch and spd_sel>0: spd_sel = spd_sel - min(step, spd_sel).
    - Mismatch and spd_sel==0: -> DWELL, dwell counter cleared.
    - No mismatch: move spd_sel toward target speed by min(step, |diff|); never overshoots; 8-bit arithmetic with no wrap (compute the difference in 9 bits).
    - If after the update spd_sel==target speed and there is no mismatch: -> HOLD if target speed != 0, else -> IDLE.
  - DWELL: spd_sel stays 0; dwell counter increments on each tick.
    - On the tick where the count reaches DWELL_TICKS: dir <= target dir, -> RAMP.
    - If the target is changed during DWELL so that mismatch clears (same dir, or speed 0): -> RAMP (or IDLE if target speed 0) on the next tick without flipping dir.
  - HOLD: outputs constant. An accepted command with a different target -> RAMP; a command equal to the current target stays in HOLD.
- at_target = (spd_sel == target speed) && (target speed==0 || dir == target dir), registered; 1 in IDLE/HOLD, 0 otherwise.
- estop=1 (sampled at a clk edge; takes priority over commands but not over reset):
  - Next cycle: spd_sel=0, en=0, cmd_ready=0, target speed=0, state=IDLE, prescaler and dwell counter cleared; dir unchanged.
  - On release, en=1 and cmd_ready=1 on the following cycle.
- Command and tick on the same edge: the tick uses the old target; the new target applies from the next cycle.
- Reset mid-ramp: immediate return to reset values, no ramp-down.

Test Plan:
1. Reset, ramp_div=4, ramp_step=10, cmd fwd 100 -> spd_sel steps 10,20,...,100, one step every 4 clks; at_target=1 and busy=0 after the 10th tick (~40 clks); dir stays 1.
2. From fwd 50 with ramp_div=1, step=10, DWELL_TICKS=3, cmd rev 30 -> spd_sel 40,30,20,10,0; 3 dwell ticks at 0; dir flips to 0; then 10,20,30; at_target=1.
3. Non-multiple step: target 25, step 10 -> 10,20,25 (no overshoot); ramp_div=0 and ramp_step=0 behave as 1 (spd_sel increments by 1 every clk).
4. estop asserted mid-ramp at spd_sel=60 -> next clk spd_sel=0, en=0, cmd_ready=0; cmd_valid ignored while high; release -> en=1, ready=1, spd_sel stays 0 until a new command.
5. Retarget mid-ramp: ramping up to 200, at 80 cmd fwd 40 -> decreases 70,60,50,40, HOLD; retarget to rev during DWELL then back to fwd -> no dir flip, ramps forward from 0.
6. rst=0 asserted during DWELL -> next clk all outputs at reset values, state IDLE; an async-style glitch on rst between edges has no effect.
